// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder.
// Two registered stages: transition minimisation, then DC balancing.
module tmds_encoder #(
   parameter int IN_WIDTH = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] data,
   input  logic                c0,
   input  logic                c1,
   input  logic                blank,
   output logic [9:0]          tmds
);

   localparam logic [9:0] CTRL00 = 10'b1101010100;
   localparam logic [9:0] CTRL01 = 10'b0010101011;
   localparam logic [9:0] CTRL10 = 10'b0101010100;
   localparam logic [9:0] CTRL11 = 10'b1010101011;

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   logic [7:0] d8;
   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] qm_d;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         d8[7-i] = data[IN_WIDTH-1-(i % IN_WIDTH)];
      end
   end

   always_comb begin
      n1d      = ones8(d8);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d8[0]);
      qm_d     = '0;
      qm_d[0]  = d8[0];
      for (int i = 1; i < 8; i++) begin
         if (use_xnor) qm_d[i] = ~(qm_d[i-1] ^ d8[i]);
         else          qm_d[i] =   qm_d[i-1] ^ d8[i];
      end
      qm_d[8] = ~use_xnor;
   end

   logic [8:0] qm_q;
   logic [3:0] n1_q;
   logic       blank_q;
   logic [1:0] c_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qm_q    <= '0;
         n1_q    <= '0;
         blank_q <= 1'b1;
         c_q     <= 2'b00;
      end else begin
         qm_q    <= qm_d;
         n1_q    <= ones8(qm_d[7:0]);
         blank_q <= blank;
         c_q     <= {c1, c0};
      end
   end

   logic signed [4:0] n1s;
   logic signed [4:0] n0s;
   logic signed [4:0] diff;
   logic signed [4:0] cnt_q;
   logic signed [4:0] cnt_d;
   logic [9:0]        tmds_q;
   logic [9:0]        tmds_d;

   assign n1s  = signed'({1'b0, n1_q});
   assign n0s  = 5'sd8 - n1s;
   assign diff = n1s - n0s;

   // Running disparity restarts at zero in every control period.
   always_comb begin
      tmds_d = CTRL00;
      cnt_d  = cnt_q;
      if (blank_q) begin
         unique case (c_q)
            2'b00: tmds_d = CTRL00;
            2'b01: tmds_d = CTRL01;
            2'b10: tmds_d = CTRL10;
            2'b11: tmds_d = CTRL11;
         endcase
         cnt_d = 5'sd0;
      end else if ((cnt_q == 5'sd0) || (n1s == n0s)) begin
         tmds_d = {~qm_q[8], qm_q[8],
                   qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 5'sd0) && (n1s > n0s)) ||
                   ((cnt_q < 5'sd0) && (n0s > n1s))) begin
         tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_d  = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmds_q <= CTRL00;
         cnt_q  <= 5'sd0;
      end else begin
         tmds_q <= tmds_d;
         cnt_q  <= cnt_d;
         assert ((cnt_d >= -5'sd8) && (cnt_d <= 5'sd8));
      end
   end

   assign tmds = tmds_q;

endmodule
